// File: rtl/msrv32_mem_responder.sv
// rtl/msrv32_mem_responder.sv - word RAM serving the msrv32 fetch port and AHB-style data port
module msrv32_mem_responder #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          MEM_DEPTH_WORDS = 4096,
    parameter int          DATA_WAIT       = 0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] i_addr_in,
    output logic [31:0] instr_out,
    output logic        instr_hready_out,
    input  logic [31:0] d_addr_in,
    input  logic [31:0] d_wdata_in,
    input  logic        d_wr_req_in,
    input  logic [3:0]  d_wr_mask_in,
    input  logic [1:0]  d_htrans_in,
    output logic [31:0] d_rdata_out,
    output logic        d_hready_out,
    output logic        d_hresp_out
);

    localparam int          AW        = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH_WORDS) << 2;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [3:0]  WAIT_INIT = 4'((DATA_WAIT > 0) ? (DATA_WAIT - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;

    logic [31:0] mem [MEM_DEPTH_WORDS];

    logic [31:0] i_off;
    logic [31:0] d_off;
    logic        i_in_range;
    logic        d_in_range;
    logic [AW-1:0] i_idx;
    logic [AW-1:0] d_idx;

    logic        accept;
    logic        wr_en;
    logic        wait_done;
    logic [31:0] resp_data;
    logic        resp_load;
    logic        unused_htrans0;

    // Offsets are compared in bytes so the low address bits fold in harmlessly
    assign i_off      = i_addr_in - BASE_ADDR;
    assign d_off      = d_addr_in - BASE_ADDR;
    assign i_in_range = (i_addr_in >= BASE_ADDR) && ({1'b0, i_off} < MEM_BYTES);
    assign d_in_range = (d_addr_in >= BASE_ADDR) && ({1'b0, d_off} < MEM_BYTES);
    assign i_idx      = i_off[AW+1:2];
    assign d_idx      = d_off[AW+1:2];

    // NONSEQ and SEQ look alike to this slave; only bit 1 marks a transfer
    assign unused_htrans0 = d_htrans_in[0];

    assign d_hready_out = (state == ST_IDLE) || (state == ST_ERR2);
    assign d_hresp_out  = (state == ST_ERR1) || (state == ST_ERR2);
    assign accept       = d_htrans_in[1] && d_hready_out && !rst_in;
    assign wr_en        = accept && d_in_range && d_wr_req_in;
    assign wait_done    = (state == ST_WAIT) && (cnt == 4'd0);

    // Byte-lane writes at the accept edge; a transfer on a reset edge never commits
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (d_wr_mask_in[b]) begin
                    mem[d_idx][8*b +: 8] <= d_wdata_in[8*b +: 8];
                end
            end
        end
    end

    // Registered fetch; same-edge data writes are not yet visible (read-before-write)
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            instr_out        <= NOP_INSTR;
            instr_hready_out <= 1'b0;
        end else begin
            instr_out        <= i_in_range ? mem[i_idx] : NOP_INSTR;
            instr_hready_out <= 1'b1;
        end
    end

    // Response capture at accept, published on d_rdata_out only when the transfer completes
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            d_rdata_out <= 32'h0;
            resp_data   <= 32'h0;
            resp_load   <= 1'b0;
        end else begin
            if (accept) begin
                if (!d_in_range) begin
                    resp_data <= 32'h0;
                    resp_load <= 1'b1;
                end else if (!d_wr_req_in) begin
                    resp_data <= mem[d_idx];
                    resp_load <= 1'b1;
                    if (DATA_WAIT == 0) begin
                        d_rdata_out <= mem[d_idx];
                    end
                end else begin
                    resp_load <= 1'b0;
                end
            end
            if ((wait_done || state == ST_ERR1) && resp_load) begin
                d_rdata_out <= resp_data;
            end
        end
    end

    // FSM state and wait counter register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; ERR2 accepts exactly like IDLE since it already signals ready
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE, ST_ERR2: begin
                state_nxt = ST_IDLE;
                if (accept) begin
                    if (!d_in_range) begin
                        state_nxt = ST_ERR1;
                    end else if (DATA_WAIT > 0) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_ERR1: begin
                state_nxt = ST_ERR2;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_msrv32_mem_responder.sv
// tb/tb_msrv32_mem_responder.sv - scoreboard bench for msrv32_mem_responder
module tb_msrv32_mem_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int WS [3] = '{0, 3, 5};

    typedef struct {
        int          inst;
        bit          is_read;
        logic [31:0] rdata;
        logic        hresp;
        int          waits;
    } dexp_t;

    typedef struct {
        int          inst;
        longint      due;
        logic [31:0] instr;
    } iexp_t;

    dexp_t  dq [$];
    iexp_t  iq [$];
    int     errors = 0;
    int     checks = 0;
    longint cyc = 0;
    logic   clk = 1'b0;

    logic        rst      [3];
    logic [31:0] i_addr   [3];
    logic [31:0] instr    [3];
    logic        ihr      [3];
    logic [31:0] d_addr   [3];
    logic [31:0] d_wdata  [3];
    logic        d_wr     [3];
    logic [3:0]  d_mask   [3];
    logic [1:0]  d_htrans [3];
    logic [31:0] d_rdata  [3];
    logic        d_hready [3];
    logic        d_hresp  [3];

    bit pend  [3];
    int nwait [3];

    always #5 clk = ~clk;

    msrv32_mem_responder #(.DATA_WAIT(0)) dut0 (
        .clk_in(clk), .rst_in(rst[0]), .i_addr_in(i_addr[0]), .instr_out(instr[0]),
        .instr_hready_out(ihr[0]), .d_addr_in(d_addr[0]), .d_wdata_in(d_wdata[0]),
        .d_wr_req_in(d_wr[0]), .d_wr_mask_in(d_mask[0]), .d_htrans_in(d_htrans[0]),
        .d_rdata_out(d_rdata[0]), .d_hready_out(d_hready[0]), .d_hresp_out(d_hresp[0]));

    msrv32_mem_responder #(.DATA_WAIT(3)) dut1 (
        .clk_in(clk), .rst_in(rst[1]), .i_addr_in(i_addr[1]), .instr_out(instr[1]),
        .instr_hready_out(ihr[1]), .d_addr_in(d_addr[1]), .d_wdata_in(d_wdata[1]),
        .d_wr_req_in(d_wr[1]), .d_wr_mask_in(d_mask[1]), .d_htrans_in(d_htrans[1]),
        .d_rdata_out(d_rdata[1]), .d_hready_out(d_hready[1]), .d_hresp_out(d_hresp[1]));

    msrv32_mem_responder #(.DATA_WAIT(5)) dut2 (
        .clk_in(clk), .rst_in(rst[2]), .i_addr_in(i_addr[2]), .instr_out(instr[2]),
        .instr_hready_out(ihr[2]), .d_addr_in(d_addr[2]), .d_wdata_in(d_wdata[2]),
        .d_wr_req_in(d_wr[2]), .d_wr_mask_in(d_mask[2]), .d_htrans_in(d_htrans[2]),
        .d_rdata_out(d_rdata[2]), .d_hready_out(d_hready[2]), .d_hresp_out(d_hresp[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Cycle counter used to time fetch expectations
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops expectations when the DUT presents a fetch result or completes a transfer
    initial forever begin
        iexp_t ie;
        dexp_t de;
        @(negedge clk);
        while (iq.size() > 0 && iq[0].due <= cyc) begin
            ie = iq.pop_front();
            chk($sformatf("instr%0d", ie.inst), instr[ie.inst], ie.instr);
            chk($sformatf("instr_hready%0d", ie.inst), {31'b0, ihr[ie.inst]}, 32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) begin
                pend[i]  = 1'b0;
                nwait[i] = 0;
            end else begin
                if (pend[i]) begin
                    if (!d_hready[i]) begin
                        nwait[i]++;
                    end else begin
                        if (dq.size() == 0) begin
                            chk($sformatf("unexpected_completion%0d", i), 32'd1, 32'd0);
                        end else begin
                            de = dq.pop_front();
                            chk("completion_inst", i, de.inst);
                            chk($sformatf("waits%0d", i), nwait[i], de.waits);
                            chk($sformatf("hresp%0d", i), {31'b0, d_hresp[i]}, {31'b0, de.hresp});
                            if (de.is_read) chk($sformatf("rdata%0d", i), d_rdata[i], de.rdata);
                        end
                        pend[i]  = 1'b0;
                        nwait[i] = 0;
                    end
                end
                if (!pend[i] && d_htrans[i][1] && d_hready[i]) pend[i] = 1'b1;
            end
        end
    end

    // Presents a NONSEQ transfer and holds it until the slave is ready to accept it
    task automatic xfer(input int i, input logic [31:0] addr, input bit w, input logic [31:0] wd,
                        input logic [3:0] m, input bit push, input bit err, input logic [31:0] exp_rd);
        bit ok;
        ok = 1'b0;
        d_addr[i]   = addr;
        d_wdata[i]  = wd;
        d_wr[i]     = w;
        d_mask[i]   = m;
        d_htrans[i] = 2'b10;
        if (push) dq.push_back('{i, !w || err, err ? 32'h0 : exp_rd, err, err ? 1 : WS[i]});
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (d_hready[i] === 1'b1) ok = 1'b1;
        end
        if (!ok) chk($sformatf("accept_timeout%0d", i), 32'd0, 32'd1);
        @(posedge clk);
        #2;
        d_htrans[i] = 2'b00;
    endtask

    task automatic fetch(input int i, input logic [31:0] addr, input logic [31:0] exp);
        i_addr[i] = addr;
        iq.push_back('{i, cyc + 1, exp});
        @(posedge clk);
        #2;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; i_addr[i] = 32'h0; d_addr[i] = 32'h0; d_wdata[i] = 32'h0;
            d_wr[i] = 1'b0; d_mask[i] = 4'h0; d_htrans[i] = 2'b00;
            pend[i] = 1'b0; nwait[i] = 0;
        end
        cycles(2);
        for (int i = 0; i < 3; i++) begin
            chk("rst_hready", {31'b0, d_hready[i]}, 32'd1);
            chk("rst_hresp", {31'b0, d_hresp[i]}, 32'd0);
            chk("rst_rdata", d_rdata[i], 32'h0);
            chk("rst_instr", instr[i], NOP);
            chk("rst_instr_hready", {31'b0, ihr[i]}, 32'd0);
            rst[i] = 1'b0;
        end

        // Preload words 0..3 back to back, then fetch them
        xfer(0, 32'h0, 1, 32'h0050_0093, 4'hF, 1, 0, 0);
        xfer(0, 32'h4, 1, 32'h00A0_0113, 4'hF, 1, 0, 0);
        xfer(0, 32'h8, 1, 32'h0020_81B3, 4'hF, 1, 0, 0);
        xfer(0, 32'hC, 1, 32'h4020_8233, 4'hF, 1, 0, 0);
        xfer(0, 32'hC, 0, 32'h0,         4'h0, 1, 0, 32'h4020_8233);
        fetch(0, 32'h0, 32'h0050_0093);
        fetch(0, 32'h4, 32'h00A0_0113);
        fetch(0, 32'h8, 32'h0020_81B3);
        fetch(0, 32'h9000, NOP);

        // Masked writes with zero wait states
        xfer(0, 32'h10, 1, 32'hAABB_CCDD, 4'b1111, 1, 0, 0);
        xfer(0, 32'h10, 1, 32'h1122_3344, 4'b0101, 1, 0, 0);
        xfer(0, 32'h13, 0, 32'h0,         4'b0000, 1, 0, 32'hAA22_CC44);
        xfer(0, 32'h10, 1, 32'hFFFF_FFFF, 4'b0000, 1, 0, 0);
        xfer(0, 32'h10, 0, 32'h0,         4'b0000, 1, 0, 32'hAA22_CC44);

        // BUSY is not a transfer
        d_htrans[0] = 2'b01;
        cycles(1);
        chk("busy_hready", {31'b0, d_hready[0]}, 32'd1);
        chk("busy_hresp", {31'b0, d_hresp[0]}, 32'd0);
        d_htrans[0] = 2'b00;

        // Out-of-range write, then a read held through ERR1 and accepted in ERR2
        xfer(0, 32'h4000, 1, 32'hDEAD_BEEF, 4'hF, 1, 1, 0);
        xfer(0, 32'h0,    0, 32'h0,         4'h0, 1, 0, 32'h0050_0093);

        // Fetch and write the same word on one edge
        i_addr[0] = 32'h10;
        iq.push_back('{0, cyc + 1, 32'hAA22_CC44});
        xfer(0, 32'h10, 1, 32'h5566_7788, 4'hF, 1, 0, 0);
        fetch(0, 32'h10, 32'h5566_7788);

        // Three wait states, pipelined request held through the wait
        xfer(1, 32'h20, 1, 32'hCAFE_F00D, 4'hF, 1, 0, 0);
        xfer(1, 32'h20, 0, 32'h0,         4'h0, 1, 0, 32'hCAFE_F00D);
        xfer(1, 32'h20, 1, 32'h1200_0000, 4'b1000, 1, 0, 0);
        xfer(1, 32'h20, 0, 32'h0,         4'h0, 1, 0, 32'h12FE_F00D);

        // Reset during WAIT; a write on a ready reset edge must not commit
        xfer(2, 32'h30, 1, 32'h0BAD_CAFE, 4'hF, 1, 0, 0);
        xfer(2, 32'h30, 1, 32'h600D_F00D, 4'hF, 0, 0, 0);
        cycles(1);
        rst[2] = 1'b1;
        d_addr[2] = 32'h30; d_wdata[2] = 32'hDEAD_DEAD; d_wr[2] = 1'b1;
        d_mask[2] = 4'hF; d_htrans[2] = 2'b10;
        cycles(1);
        chk("midwait_rst_hready", {31'b0, d_hready[2]}, 32'd1);
        chk("midwait_rst_hresp", {31'b0, d_hresp[2]}, 32'd0);
        cycles(1);
        rst[2] = 1'b0;
        d_htrans[2] = 2'b00;
        xfer(2, 32'h30, 0, 32'h0, 4'h0, 1, 0, 32'h600D_F00D);

        for (int n = 0; n < 60 && (dq.size() > 0 || iq.size() > 0); n++) cycles(1);
        chk("pending_expectations", dq.size() + iq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/msrv32_mem_responder.md
# msrv32_mem_responder

Single-clock memory responder serving both bus masters of the msrv32 core: the instruction fetch port and the AHB-style data port. It holds a word-organised RAM, returns instructions every cycle, and performs data reads and masked writes with a configurable number of wait states. Out-of-range data transfers get an AHB two-cycle ERROR response. It is the slave end of the core's `imaddr`/`instr`/`dm*`/`htrans`/`hready`/`hresp` interface and is used in simulation tops and FPGA builds.

## Interface

**Parameters**
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0.
- `MEM_DEPTH_WORDS`, 4096: number of 32-bit words. Must be a power of two.
- `DATA_WAIT`, 0: wait states inserted per data transfer, 0..15.

**Ports** (clock and reset first; one clock; reset is synchronous and active-high)
- `clk_in`  input  1  clock; all state updates on the rising edge.
- `rst_in`  input  1  synchronous, active-high reset.
- `i_addr_in`  input  32  instruction fetch byte address.
- `instr_out`  output  32  fetched instruction, registered.
- `instr_hready_out`  output  1  instruction valid/ready.
- `d_addr_in`  input  32  data byte address (word-aligned by the core).
- `d_wdata_in`  input  32  write data, valid together with the address.
- `d_wr_req_in`  input  1  1 = write, 0 = read.
- `d_wr_mask_in`  input  4  byte enables; bit n = byte lane n.
- `d_htrans_in`  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `d_rdata_out`  output  32  read data.
- `d_hready_out`  output  1  transfer complete / slave ready.
- `d_hresp_out`  output  1  0 OKAY, 1 ERROR.

## Operation

**Instruction port**
- Each cycle, `instr_out` <= `mem[(i_addr_in-BASE_ADDR)>>2]`.
- Out-of-range addresses return 32'h0000_0013 (NOP).
- `instr_hready_out` is 1 in every cycle after reset.

**Data transfers**
- Word index = `(d_addr_in-BASE_ADDR)>>2`. Address bits [1:0] are ignored.
- The address is out of range if `d_addr_in < BASE_ADDR` or index >= `MEM_DEPTH_WORDS`.
- A transfer is accepted on an edge where `d_htrans_in[1]==1` and `d_hready_out==1`.
- IDLE and BUSY are not transfers. They get `d_hready_out=1` and `d_hresp_out=0`.

**In-range write**
- At the accept edge, each byte lane with its mask bit set is written from `d_wdata_in`. Other lanes are unchanged.
- Mask 0000 is a legal no-op.

**In-range read**
- At the accept edge, the memory word is captured into a response register.
- The captured word appears on `d_rdata_out` when the transfer completes.

**Out-of-range transfer**
- No write is performed.
- The response register is loaded with 0.

**FSM states**
- IDLE: `d_hready_out=1`, `d_hresp_out=0`.
- WAIT: `d_hready_out=0`, `d_hresp_out=0`.
- ERR1: `d_hready_out=0`, `d_hresp_out=1`.
- ERR2: `d_hready_out=1`, `d_hresp_out=1`.

**FSM transitions**
- IDLE, accept, out of range -> ERR1.
- IDLE, accept, in range, `DATA_WAIT=0` -> IDLE. The response completes in the next cycle.
- IDLE, accept, in range, `DATA_WAIT>0` -> WAIT, with counter loaded to `DATA_WAIT-1`.
- WAIT: counter decrements each cycle; at 0 -> IDLE.
- ERR1 -> ERR2.
- ERR2, accept -> evaluated exactly as in IDLE. No accept -> IDLE.
- `d_htrans_in`, `d_addr_in` and `d_wdata_in` are ignored while `d_hready_out=0`.

**Read data visibility**
- `d_rdata_out` updates at completion only.
- `d_rdata_out` holds its value otherwise.

**Collisions**
- Fetch and data write to the same word on the same edge: the fetch returns the old data (read-before-write).
- Data read of a word written by the immediately preceding transfer returns the new data.

**Reset**
- Reset returns the FSM to IDLE and clears the counter.
- A transfer presented on the reset edge is dropped and its write is not performed.
- Memory contents are not reset.

## Timing

**Reset values**
- `d_hready_out=1`, `d_hresp_out=0`, `d_rdata_out=0`.
- `instr_out=32'h0000_0013`, `instr_hready_out=0`.

**Instruction latency**
- `instr_out` is valid one cycle after `i_addr_in`.

**Data latency, accept at edge k**
- `DATA_WAIT=0`: `d_hready_out=1` throughout. Read data is valid in the cycle after edge k.
- `DATA_WAIT=N`: `d_hready_out=0` for N cycles after edge k. It returns to 1 on cycle N+1 with data valid.

**Pipelining**
- The completing cycle (`d_hready_out=1`) may also accept the next transfer.
- With `DATA_WAIT=0`, back-to-back transfers sustain one per cycle.

**Error response**
- Exactly 2 cycles: (hready 0, hresp 1) then (hready 1, hresp 1).

## Test plan

- **Reset/fetch:** preload mem[0..3]; pulse `rst_in` 2 cycles, then drive `i_addr_in` 0,4,8 -> each word appears 1 cycle later; `instr_hready_out` 0 in reset, 1 after.
- **Masked write, 0 wait:**
  - Write 32'hAABBCCDD with mask 1111 to 0x10, then 32'h11223344 with mask 0101.
  - Read 0x10 -> `d_rdata_out=32'hAA22CC44`.
  - `d_hready_out` never drops.
- **Wait states:** `DATA_WAIT=3`; read 0x20 -> `d_hready_out` low for exactly 3 cycles, high on the 4th with data; a NONSEQ held during wait is accepted only on the completing cycle.
- **Error:** `MEM_DEPTH_WORDS=4096`, write to 0x4000 -> hready/hresp sequence 0/1 then 1/1, no memory change, `d_rdata_out=0`; a NONSEQ in ERR2 is accepted.
- **Collision:** fetch and write same word at the same edge -> old instruction returned; fetch next cycle -> new value.
- **Reset mid-wait:** `DATA_WAIT=5`, assert `rst_in` during WAIT -> next cycle `d_hready_out=1`, `d_hresp_out=0`; a write on the reset edge is not committed.
